// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths and constants for the MIPS pipeline
package mips_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush-over-stall priority
module if_id_reg
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               stall,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [ADDR_W-1:0]  pc_plus4_d,
    input  logic               valid_d,
    output logic [INSTR_W-1:0] instr_q,
    output logic [ADDR_W-1:0]  pc_plus4_q,
    output logic               valid_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (flush) begin
            // a squashed slot still tracks pc_plus4 so the link/base stays coherent
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= 1'b0;
        end else if (!stall) begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - PC register, next-PC selection and fetch fault detection
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                IMEM_DEPTH = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               branch_taken_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    input  logic               jump_i,
    input  logic [ADDR_W-1:0]  jump_target_i,
    input  logic [INSTR_W-1:0] imem_instr_i,
    output logic [ADDR_W-1:0]  imem_pc_o,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic [ADDR_W-1:0]  if_id_pc_plus4_o,
    output logic               if_id_valid_o,
    output logic               fetch_fault_o
);

    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  word_idx;
    logic               fault_now;
    logic               fault_q;
    logic [INSTR_W-1:0] fetched_instr;

    assign imem_pc_o = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign word_idx  = {2'b00, pc_q[ADDR_W-1:2]};
    assign fault_now = (pc_q[1:0] != 2'b00) || (word_idx >= 32'(IMEM_DEPTH));
    assign fetched_instr = fault_now ? NOP_INSTR : imem_instr_i;

    // branch is from the older instruction, so it beats jump; any redirect beats stall
    always_comb begin
        pc_d = pc_plus4;
        if (branch_taken_i)
            pc_d = branch_target_i;
        else if (jump_i)
            pc_d = jump_target_i;
        else if (stall_i)
            pc_d = pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fault_q <= 1'b0;
        else if (fault_now && !stall_i && !flush_i)
            fault_q <= 1'b1;
    end

    assign fetch_fault_o = fault_q;

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_i),
        .stall      (stall_i),
        .instr_d    (fetched_instr),
        .pc_plus4_d (pc_plus4),
        .valid_d    (~fault_now),
        .instr_q    (if_id_instr_o),
        .pc_plus4_q (if_id_pc_plus4_o),
        .valid_q    (if_id_valid_o)
    );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed and randomized checks against a behavioural fetch model
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_target_i = '0;
    logic [31:0] imem_instr_i;
    logic [31:0] imem_pc_o;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc_plus4_o;
    logic        if_id_valid_o;
    logic        fetch_fault_o;

    logic [31:0] mem [0:127];

    int vecs = 0;
    int errs = 0;

    // reference state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_fault;

    always #5 clk = ~clk;

    assign imem_instr_i = mem[imem_pc_o[8:2]];

    instruction_fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_DEPTH(100)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .branch_taken_i   (branch_taken_i),
        .branch_target_i  (branch_target_i),
        .jump_i           (jump_i),
        .jump_target_i    (jump_target_i),
        .imem_instr_i     (imem_instr_i),
        .imem_pc_o        (imem_pc_o),
        .if_id_instr_o    (if_id_instr_o),
        .if_id_pc_plus4_o (if_id_pc_plus4_o),
        .if_id_valid_o    (if_id_valid_o),
        .fetch_fault_o    (fetch_fault_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_pc"},    imem_pc_o, m_pc);
        chk({tag, "_instr"}, if_id_instr_o, m_instr);
        chk({tag, "_pc4"},   if_id_pc_plus4_o, m_pc4);
        chk({tag, "_valid"}, {31'd0, if_id_valid_o}, {31'd0, m_valid});
        chk({tag, "_fault"}, {31'd0, fetch_fault_o}, {31'd0, m_fault});
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
    endtask

    // one clock of the fetch stage, described directly from its rules
    task automatic step(input string tag, input logic st, input logic fl,
                        input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt);
        logic bad;
        logic [31:0] seq;
        stall_i = st; flush_i = fl;
        branch_taken_i = br; branch_target_i = bt;
        jump_i = jp; jump_target_i = jt;
        bad = (m_pc % 4 != 0) || ((m_pc / 4) >= 100);
        seq = m_pc + 32'd4;
        if (fl) begin
            m_instr = 32'h0; m_valid = 1'b0; m_pc4 = seq;
        end else if (!st) begin
            m_instr = bad ? 32'h0 : mem[m_pc[8:2]];
            m_valid = !bad;
            m_pc4   = seq;
            if (bad) m_fault = 1'b1;
        end
        if (br)      m_pc = bt;
        else if (jp) m_pc = jt;
        else if (!st) m_pc = seq;
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        stall_i = 0; flush_i = 0; branch_taken_i = 0; jump_i = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + 32'(i * 4);
        model_reset();
        #2;
        chk_all("reset");
        apply_reset();

        // 1: free-running fetch
        step("t1a", 0, 0, 0, 0, 0, 0);
        chk("t1_instr_const", if_id_instr_o, 32'h1000_0000);
        chk("t1_pc4_const", if_id_pc_plus4_o, 32'h4);
        step("t1b", 0, 0, 0, 0, 0, 0);
        chk("t1_pc8", imem_pc_o, 32'h8);
        // 2: stall at PC=8
        step("t2a", 1, 0, 0, 0, 0, 0);
        step("t2b", 1, 0, 0, 0, 0, 0);
        chk("t2_pc_held", imem_pc_o, 32'h8);
        step("t2c", 0, 0, 0, 0, 0, 0);
        chk("t2_pc_c", imem_pc_o, 32'hC);
        // 3: branch beats jump, flushed
        step("t3", 0, 1, 1, 32'h40, 1, 32'h80);
        chk("t3_pc40", imem_pc_o, 32'h40);
        // 4: jump overrides stall
        step("t4", 1, 0, 0, 0, 1, 32'h20);
        chk("t4_pc20", imem_pc_o, 32'h20);
        // 5: misaligned and out-of-range fetches
        step("t5a", 0, 0, 1, 32'h22, 0, 0);
        step("t5b", 0, 0, 1, 32'h190, 0, 0);
        chk("t5_nop_misaligned", {31'd0, if_id_valid_o}, 32'd0);
        chk("t5_fault_set", {31'd0, fetch_fault_o}, 32'd1);
        step("t5c", 0, 0, 0, 0, 0, 0);
        chk("t5_valid_oor", {31'd0, if_id_valid_o}, 32'd0);
        step("t5d", 0, 0, 0, 0, 1, 32'h0);
        step("t5e", 0, 0, 0, 0, 0, 0);
        chk("t5_fault_sticky", {31'd0, fetch_fault_o}, 32'd1);
        // PC wrap at the top of the address space
        step("wrap_a", 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        step("wrap_b", 0, 0, 0, 0, 0, 0);
        chk("wrap_pc", imem_pc_o, 32'h0);
        chk("wrap_pc4", if_id_pc_plus4_o, 32'h0);
        // 6: asynchronous reset mid-cycle at PC=0x30
        step("t6a", 0, 0, 0, 0, 1, 32'h30);
        step("t6b", 0, 0, 0, 0, 0, 0);
        step("t6c", 0, 0, 1, 32'h30, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // randomized traffic with new memory contents
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        for (int n = 0; n < 300; n++) begin
            logic st, fl, br, jp;
            logic [31:0] bt, jt;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 5) == 0);
            br = ($urandom_range(0, 9) == 0);
            jp = ($urandom_range(0, 9) == 0);
            bt = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 99)) << 2;
            jt = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 99)) << 2;
            step("rand", st, fl, br, bt, jp, jt);
            if (n == 150) apply_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
